// File: rtl/fifo_sync_ext.sv
// ---------------------------------------------------------------------------
// fifo_sync_ext
//
// Single-clock FIFO with programmable almost-full / almost-empty levels,
// a synchronous flush and sticky overflow / underflow error flags.
// The read side works in one of two modes:
//   FWFT = 0 : registered read, read_data updates on the edge that accepts
//              a read and holds otherwise.
//   FWFT = 1 : first-word-fall-through, the head entry is visible on
//              read_data whenever the FIFO is not empty.
//
// Parameters
//   FIFO_DEPTH      number of entries (power of two, >= 2)
//   FIFO_DATA_WIDTH entry width in bits
//   FWFT            read mode select (see above)
//   CNT_W           width of pointers, count and thresholds
//
// Ports
//   clk           single clock, rising edge
//   reset         synchronous active-high reset (highest priority)
//   flush         synchronous clear of pointers/count; write/read ignored
//   write         write request
//   write_data    write payload
//   read          read request
//   read_data     read payload
//   afull_thresh  almost_full asserts when count >= this level
//   aempty_thresh almost_empty asserts when count <= this level
//   count         current occupancy, 0..FIFO_DEPTH
//   empty, full   occupancy status, derived from the registered count
//   almost_empty  count <= aempty_thresh
//   almost_full   count >= afull_thresh
//   overflow      sticky: write attempted while full
//   underflow     sticky: read attempted while empty
//   err_clear     clears the sticky flags (a new error in the same cycle wins)
// ---------------------------------------------------------------------------
module fifo_sync_ext #(
    parameter int FIFO_DEPTH      = 32'd8,
    parameter int FIFO_DATA_WIDTH = 32'd8,
    parameter bit FWFT            = 1'b0,
    localparam int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       write,
    input  logic [FIFO_DATA_WIDTH-1:0] write_data,
    input  logic                       read,
    output logic [FIFO_DATA_WIDTH-1:0] read_data,
    input  logic [CNT_W-1:0]           afull_thresh,
    input  logic [CNT_W-1:0]           aempty_thresh,
    output logic [CNT_W-1:0]           count,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_empty,
    output logic                       almost_full,
    output logic                       overflow,
    output logic                       underflow,
    input  logic                       err_clear
);

    // Storage is addressed by the low pointer bits; the extra MSB of each
    // pointer lets them run modulo 2*FIFO_DEPTH with no wrap logic.
    localparam int ADDR_W = CNT_W - 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] ZERO_C  = {CNT_W{1'b0}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [FIFO_DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
    logic [CNT_W-1:0]           wr_ptr_r;
    logic [CNT_W-1:0]           rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       overflow_r;
    logic                       underflow_r;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic                       full_s;
    logic                       empty_s;
    logic                       wr_acc_s;
    logic                       rd_acc_s;
    logic                       ovf_set_s;
    logic                       unf_set_s;
    logic [CNT_W-1:0]           count_nxt_s;
    logic                       overflow_nxt_s;
    logic                       underflow_nxt_s;
    logic [ADDR_W-1:0]          wr_idx_s;
    logic [ADDR_W-1:0]          rd_idx_s;

    // Status comes only from the registered count, so there is no path
    // from write/read to full/empty.
    assign full_s   = (count_r == DEPTH_C);
    assign empty_s  = (count_r == ZERO_C);
    assign wr_idx_s = wr_ptr_r[ADDR_W-1:0];
    assign rd_idx_s = rd_ptr_r[ADDR_W-1:0];

    // Accept qualification: full/empty are the registered values, so a
    // read in the same cycle never makes room for a write into a full FIFO.
    always_comb begin
        wr_acc_s = 1'b0;
        rd_acc_s = 1'b0;
        if (!reset && !flush) begin
            wr_acc_s = write && !full_s;
            rd_acc_s = read && !empty_s;
        end else begin
            wr_acc_s = 1'b0;
            rd_acc_s = 1'b0;
        end
    end

    // Occupancy update: +1 write only, -1 read only, hold otherwise.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + ONE_C;
            2'b01:   count_nxt_s = count_r - ONE_C;
            default: count_nxt_s = count_r;
        endcase
    end

    // Sticky error flags: a new error in this cycle beats err_clear.
    always_comb begin
        ovf_set_s       = write && full_s && !flush;
        unf_set_s       = read && empty_s && !flush;
        overflow_nxt_s  = overflow_r;
        underflow_nxt_s = underflow_r;
        if (ovf_set_s) begin
            overflow_nxt_s = 1'b1;
        end else if (err_clear) begin
            overflow_nxt_s = 1'b0;
        end else begin
            overflow_nxt_s = overflow_r;
        end
        if (unf_set_s) begin
            underflow_nxt_s = 1'b1;
        end else if (err_clear) begin
            underflow_nxt_s = 1'b0;
        end else begin
            underflow_nxt_s = underflow_r;
        end
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Pointers, count and sticky flags; reset beats flush beats traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r    <= ZERO_C;
            rd_ptr_r    <= ZERO_C;
            count_r     <= ZERO_C;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else if (flush) begin
            // Flush empties the FIFO but leaves the error history alone.
            wr_ptr_r    <= ZERO_C;
            rd_ptr_r    <= ZERO_C;
            count_r     <= ZERO_C;
            overflow_r  <= overflow_r;
            underflow_r <= underflow_r;
        end else begin
            if (wr_acc_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_C;
            end
            if (rd_acc_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_C;
            end
            count_r     <= count_nxt_s;
            overflow_r  <= overflow_nxt_s;
            underflow_r <= underflow_nxt_s;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wr_idx_s] <= write_data;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    generate
        if (FWFT) begin : g_fwft
            // Head entry is visible directly. Memory and count update on
            // the same edge, so the first word appears as empty drops.
            // While empty the value is stale and must be ignored.
            assign read_data = mem_r[rd_idx_s];
        end else begin : g_registered
            logic [FIFO_DATA_WIDTH-1:0] read_data_r;

            // Registered read: load the head on an accepted read, else hold.
            always_ff @(posedge clk) begin
                if (reset) begin
                    read_data_r <= {FIFO_DATA_WIDTH{1'b0}};
                end else if (flush) begin
                    read_data_r <= {FIFO_DATA_WIDTH{1'b0}};
                end else if (rd_acc_s) begin
                    read_data_r <= mem_r[rd_idx_s];
                end else begin
                    read_data_r <= read_data_r;
                end
            end

            assign read_data = read_data_r;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign count        = count_r;
    assign full         = full_s;
    assign empty        = empty_s;
    // Thresholds are live inputs; a change is reflected without a clock.
    assign almost_full  = (count_r >= afull_thresh);
    assign almost_empty = (count_r <= aempty_thresh);
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

endmodule

// File: tb/tb_fifo_sync_ext.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_ext
//
// Self-checking bench for fifo_sync_ext. Instance u_dut uses the default
// configuration (DEPTH 8, registered read); u_fwft uses FWFT=1.
// Vectors carry inputs plus expected status; a queue scoreboard supplies
// the expected read data in write order.
// ---------------------------------------------------------------------------
module tb_fifo_sync_ext;

    localparam int DEPTH = 8;
    localparam int CW    = 4;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    // registered-read instance
    logic          reset, flush, write, read, err_clear;
    logic [7:0]    write_data, read_data;
    logic [CW-1:0] afull_thresh, aempty_thresh, count;
    logic          empty, full, almost_empty, almost_full, overflow, underflow;

    // FWFT instance
    logic          b_reset, b_flush, b_write, b_read, b_err_clear;
    logic [7:0]    b_write_data, b_read_data;
    logic [CW-1:0] b_afull, b_aempty, b_count;
    logic          b_empty, b_full, b_ae, b_af, b_ovf, b_unf;

    fifo_sync_ext #(.FIFO_DEPTH(8), .FIFO_DATA_WIDTH(8), .FWFT(1'b0)) u_dut (
        .clk(clk), .reset(reset), .flush(flush), .write(write),
        .write_data(write_data), .read(read), .read_data(read_data),
        .afull_thresh(afull_thresh), .aempty_thresh(aempty_thresh),
        .count(count), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow), .err_clear(err_clear)
    );

    fifo_sync_ext #(.FIFO_DEPTH(8), .FIFO_DATA_WIDTH(8), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(b_reset), .flush(b_flush), .write(b_write),
        .write_data(b_write_data), .read(b_read), .read_data(b_read_data),
        .afull_thresh(b_afull), .aempty_thresh(b_aempty),
        .count(b_count), .empty(b_empty), .full(b_full),
        .almost_empty(b_ae), .almost_full(b_af),
        .overflow(b_ovf), .underflow(b_unf), .err_clear(b_err_clear)
    );

    typedef struct {
        logic       wr;
        logic [7:0] wd;
        logic       rd;
        logic       fl;
        logic       ec;
        logic [3:0] e_cnt;
        logic       e_empty;
        logic       e_full;
        logic       e_ae;
        logic       e_af;
        logic       e_ovf;
        logic       e_unf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         mdl_count;
    logic [7:0] mdl_rd;
    int         n_chk  = 0;
    int         n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Build a vector; status expectations follow from the expected count
    // and the thresholds currently applied.
    function automatic vec_t mk(logic wr, logic [7:0] wd, logic rd, logic fl, logic ec,
                                int cnt, logic ovf, logic unf);
        vec_t v;
        v.wr = wr; v.wd = wd; v.rd = rd; v.fl = fl; v.ec = ec;
        v.e_cnt   = 4'(cnt);
        v.e_empty = (cnt == 0);
        v.e_full  = (cnt == DEPTH);
        v.e_ae    = (cnt <= int'(aempty_thresh));
        v.e_af    = (cnt >= int'(afull_thresh));
        v.e_ovf   = ovf;
        v.e_unf   = unf;
        return v;
    endfunction

    task automatic apply(input vec_t v, input string tag);
        logic wacc, racc;
        wacc = v.wr && (mdl_count < DEPTH) && !v.fl;
        racc = v.rd && (mdl_count > 0) && !v.fl;
        write = v.wr; write_data = v.wd; read = v.rd; flush = v.fl; err_clear = v.ec;
        if (v.fl) begin
            sb.delete();
            mdl_count = 0;
            mdl_rd = 8'h00;
        end else begin
            if (racc) begin
                if (sb.size() > 0) mdl_rd = sb.pop_front();
                else chk({tag, ".sb_empty"}, 32'd1, 32'd0);
                mdl_count--;
            end
            if (wacc) begin
                sb.push_back(v.wd);
                mdl_count++;
            end
        end
        tick();
        chk({tag, ".count"},     32'(count),     32'(v.e_cnt));
        chk({tag, ".empty"},     32'(empty),     32'(v.e_empty));
        chk({tag, ".full"},      32'(full),      32'(v.e_full));
        chk({tag, ".aempty"},    32'(almost_empty), 32'(v.e_ae));
        chk({tag, ".afull"},     32'(almost_full),  32'(v.e_af));
        chk({tag, ".overflow"},  32'(overflow),  32'(v.e_ovf));
        chk({tag, ".underflow"}, 32'(underflow), 32'(v.e_unf));
        chk({tag, ".read_data"}, 32'(read_data), 32'(mdl_rd));
        write = 1'b0; read = 1'b0; flush = 1'b0; err_clear = 1'b0;
    endtask

    task automatic do_reset(input logic fl, input logic wr, input logic rd, input string tag);
        reset = 1'b1; flush = fl; write = wr; write_data = 8'h7F; read = rd;
        tick();
        sb.delete();
        mdl_count = 0;
        mdl_rd = 8'h00;
        chk({tag, ".count"},     32'(count),     32'd0);
        chk({tag, ".empty"},     32'(empty),     32'd1);
        chk({tag, ".full"},      32'(full),      32'd0);
        chk({tag, ".overflow"},  32'(overflow),  32'd0);
        chk({tag, ".underflow"}, 32'(underflow), 32'd0);
        chk({tag, ".read_data"}, 32'(read_data), 32'd0);
        chk({tag, ".aempty"},    32'(almost_empty), 32'd1);
        chk({tag, ".afull"},     32'(almost_full),  32'd0);
        reset = 1'b0; flush = 1'b0; write = 1'b0; read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; flush = 1'b0; write = 1'b0; read = 1'b0; err_clear = 1'b0;
        write_data = 8'h00; afull_thresh = 4'd6; aempty_thresh = 4'd1;
        b_reset = 1'b1; b_flush = 1'b0; b_write = 1'b0; b_read = 1'b0;
        b_err_clear = 1'b0; b_write_data = 8'h00; b_afull = 4'd6; b_aempty = 4'd1;
        mdl_count = 0; mdl_rd = 8'h00;
        tick();
        do_reset(1'b0, 1'b0, 1'b0, "reset");

        // Fill to full, overflow, drain in order, then error-flag behaviour.
        vecs.delete();
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b1, 8'(i + 1), 1'b0, 1'b0, 1'b0, i + 1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 8, 1'b1, 1'b0));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 7 - i, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b0));
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Steady state at count 4 with pointers wrapping.
        for (int i = 0; i < 4; i++) apply(mk(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0, 1'b0, i + 1, 1'b0, 1'b0), "pre4");
        for (int i = 0; i < 20; i++) apply(mk(1'b1, 8'h20 + 8'(i), 1'b1, 1'b0, 1'b0, 4, 1'b0, 1'b0), $sformatf("rw%0d", i));
        for (int i = 0; i < 4; i++) apply(mk(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b0, 5 + i, 1'b0, 1'b0), "fill");
        // Full with both asserted: read wins a slot, write still rejected.
        apply(mk(1'b1, 8'h50, 1'b1, 1'b0, 1'b0, 7, 1'b1, 1'b0), "full_rw");
        for (int i = 0; i < 3; i++) apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 6 - i, 1'b1, 1'b0), "down4");

        // Threshold change at count 4 takes effect without a clock edge.
        afull_thresh = 4'd3; aempty_thresh = 4'd0;
        #1;
        chk("thr.afull",  32'(almost_full),  32'd1);
        chk("thr.aempty", 32'(almost_empty), 32'd0);

        // Flush at count 5 with write asserted; sticky overflow survives.
        apply(mk(1'b1, 8'h60, 1'b0, 1'b0, 1'b0, 5, 1'b1, 1'b0), "up5");
        apply(mk(1'b1, 8'h61, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0), "flush");
        afull_thresh = 4'd6; aempty_thresh = 4'd1;
        apply(mk(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1, 1'b1, 1'b0), "postfl_w");
        apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0), "postfl_r");
        do_reset(1'b1, 1'b0, 1'b0, "rst_fl");

        // Reset in the middle of traffic discards everything.
        for (int i = 0; i < 3; i++) apply(mk(1'b1, 8'h70 + 8'(i), 1'b0, 1'b0, 1'b0, i + 1, 1'b0, 1'b0), "mid");
        do_reset(1'b0, 1'b1, 1'b1, "rst_mid");
        apply(mk(1'b1, 8'h80, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0), "after_w");
        apply(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0), "after_r");

        // FWFT instance: head visible as soon as empty drops.
        b_reset = 1'b0;
        tick();
        chk("fwft.empty0", 32'(b_empty), 32'd1);
        b_write = 1'b1; b_write_data = 8'hA5;
        tick();
        b_write = 1'b0;
        chk("fwft.empty1", 32'(b_empty), 32'd0);
        chk("fwft.head1",  32'(b_read_data), 32'hA5);
        b_write = 1'b1; b_write_data = 8'hB6;
        tick();
        b_write = 1'b0;
        chk("fwft.head2",  32'(b_read_data), 32'hA5);
        chk("fwft.count2", 32'(b_count), 32'd2);
        b_read = 1'b1;
        tick();
        chk("fwft.next",   32'(b_read_data), 32'hB6);
        chk("fwft.count1", 32'(b_count), 32'd1);
        tick();
        b_read = 1'b0;
        chk("fwft.empty2", 32'(b_empty), 32'd1);
        chk("fwft.unf",    32'(b_unf), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fifo_sync_ext.md
FIFO_SYNC_EXT -- requirements
Module: fifo_sync_ext

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: number of entries; power of two, at least 2.
REQ-002 SHALL have parameter FIFO_DATA_WIDTH, default 8: entry width in bits.
REQ-003 SHALL have parameter FWFT, default 0: read mode (0 = registered read, 1 = first-word-fall-through).
REQ-004 SHALL use CNT_W = $clog2(FIFO_DEPTH)+1 for pointers, count and thresholds.
REQ-005 SHALL have port clk, input, 1: the single clock; all logic updates on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port flush, input, 1: synchronous FIFO clear.
REQ-008 SHALL have port write, input, 1: write request.
REQ-009 SHALL have port write_data, input, FIFO_DATA_WIDTH: write payload.
REQ-010 SHALL have port read, input, 1: read request.
REQ-011 SHALL have port read_data, output, FIFO_DATA_WIDTH: read payload.
REQ-012 SHALL have port afull_thresh, input, CNT_W: almost-full level.
REQ-013 SHALL have port aempty_thresh, input, CNT_W: almost-empty level.
REQ-014 SHALL have port count, output, CNT_W: current occupancy, 0..FIFO_DEPTH.
REQ-015 SHALL have ports empty, full, almost_empty and almost_full, outputs, 1 each: status flags.
REQ-016 SHALL have ports overflow and underflow, outputs, 1 each: sticky error flags.
REQ-017 SHALL have port err_clear, input, 1: clears the sticky error flags.

Function
REQ-018 SHALL accept a write iff write && !full && !flush; the entry is stored at wr_ptr and wr_ptr increments.
REQ-019 SHALL accept a read iff read && !empty && !flush; rd_ptr increments.
REQ-020 SHALL NOT let a write bypass a full FIFO, even if a read is accepted in the same cycle.
REQ-021 SHALL update count by +1 (write only), -1 (read only) or 0 (both or neither).
REQ-022 SHALL index storage with the low CNT_W-1 pointer bits, so pointers wrap modulo 2*FIFO_DEPTH without special handling.
REQ-023 SHALL derive full = (count == FIFO_DEPTH) and empty = (count == 0) from registered count, with no combinational path from write or read.
REQ-024 SHALL set almost_full = (count >= afull_thresh) and almost_empty = (count <= aempty_thresh), comparing unsigned; thresholds may change at any time and take effect immediately.
REQ-025 SHALL, in FWFT=0, load read_data with the head entry on the edge that accepts a read (1-cycle latency) and otherwise hold it.
REQ-026 SHALL, in FWFT=1, present the head entry on read_data whenever !empty; a read consumes it and the next entry appears after that edge; read_data is don't-care while empty.
REQ-027 SHALL, in FWFT=1, present the first written entry on read_data on the same edge that deasserts empty.
REQ-028 SHALL set overflow on any cycle with write && full && !flush, and set underflow on any cycle with read && empty && !flush.
REQ-029 SHALL clear overflow and underflow on err_clear, with set winning over clear in the same cycle.
REQ-030 SHALL, on flush, zero wr_ptr, rd_ptr and count on the next edge, zero read_data in FWFT=0, ignore write and read, and leave the sticky flags unchanged.
REQ-031 SHALL give reset priority over flush, and flush priority over write and read.

Reset
REQ-032 SHALL, on reset, zero wr_ptr, rd_ptr, count, read_data, overflow and underflow, giving empty=1 and full=0.
REQ-033 SHALL leave storage contents unreset; no output may depend on unwritten entries except read_data when empty in FWFT=1.
REQ-034 SHALL, on reset asserted mid-traffic, discard all entries and ignore any write or read in that cycle.

Verification
REQ-035 SHALL check: DEPTH=8, FWFT=0, write 0x01..0x08 -> full=1, count=8; a 9th write -> overflow=1, count=8; 8 reads -> read_data 0x01..0x08 each one cycle after its read, then empty=1.
REQ-036 SHALL check: FWFT=1, write 0xA5 on an empty FIFO -> next cycle empty=0 and read_data=0xA5 with no read issued; read -> empty=1.
REQ-037 SHALL check: count=4, simultaneous write and read for 20 cycles -> count stays 4, pointers wrap, data order preserved; full FIFO with both asserted -> read accepted, write rejected, overflow=1.
REQ-038 SHALL check: afull_thresh=6, aempty_thresh=1 -> almost_empty=1 at count 0..1 and almost_full=1 at count 6..8; thresholds changed to 3/0 at count 4 -> almost_full=1 and almost_empty=0 immediately.
REQ-039 SHALL check: read on empty -> underflow=1; err_clear alone -> 0 next cycle; err_clear with read on empty -> underflow stays 1.
REQ-040 SHALL check: count=5, flush asserted with write=1 -> next cycle count=0 and empty=1, write ignored, overflow/underflow unchanged; reset with flush asserted -> all outputs at their reset values.
